// File: rtl/exec_pkg.sv
// Shared encodings for the execute-stage ALU and the iterative multiply/divide path.
package exec_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  // Base-op control decode; unlisted R/I-type combinations fall back to ADD.
  function automatic logic [3:0] base_ctrl(input logic [1:0] alu_op,
                                           input logic       f7_5,
                                           input logic [2:0] f3);
    logic [3:0] c;
    c = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: c = ALU_SUB;
      ALUOP_RTYPE: begin
        case ({f7_5, f3})
          4'b0000: c = ALU_ADD;
          4'b1000: c = ALU_SUB;
          4'b0001: c = ALU_SLL;
          4'b0010: c = ALU_SLT;
          4'b0011: c = ALU_SLTU;
          4'b0100: c = ALU_XOR;
          4'b0101: c = ALU_SRL;
          4'b1101: c = ALU_SRA;
          4'b0110: c = ALU_OR;
          4'b0111: c = ALU_AND;
          default: c = ALU_ADD;
        endcase
      end
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider with sign fix-up.
// Runs one iteration per cycle while run is high; res_c is valid in the fix-up cycle.
module mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic            run,
  input  logic            is_div,
  input  logic            sel_hi,
  input  logic            a_signed,
  input  logic            b_signed,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            last_c,
  output logic [XLEN-1:0] res_c
);

  localparam int unsigned CW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              sel_hi_q, sel_hi_d;
  logic              neg_q, neg_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     part;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;

  always_comb begin
    a_neg = a_signed & op_a[XLEN-1];
    b_neg = b_signed & op_b[XLEN-1];
    mag_a = a_neg ? -op_a : op_a;
    mag_b = b_neg ? -op_b : op_b;
  end

  assign last_c = run & (cnt_q == CW'(XLEN - 1));

  // Mul: acc = {partial, multiplier}. Div: acc = {remainder, dividend/quotient}.
  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sel_hi_d = sel_hi_q;
    neg_d    = neg_q;
    part     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    if (flush) begin
      cnt_d = '0;
    end else if (start) begin
      acc_d    = is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
      opnd_d   = is_div ? mag_b : mag_a;
      cnt_d    = '0;
      is_div_d = is_div;
      sel_hi_d = sel_hi;
      neg_d    = (is_div & sel_hi) ? a_neg : (a_neg ^ b_neg);
    end else if (run) begin
      cnt_d = last_c ? '0 : cnt_q + CW'(1);
      if (is_div_q) begin
        acc_d = {(rem_ge ? XLEN'(rem_sh - {1'b0, opnd_q}) : rem_sh[XLEN-1:0]),
                 acc_q[XLEN-2:0], rem_ge};
      end else begin
        acc_d = {part, acc_q[XLEN-1:1]};
      end
    end
  end

  always_comb begin
    prod  = neg_q ? -acc_q : acc_q;
    quo   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem   = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (is_div_q) res_c = sel_hi_q ? rem : quo;
    else          res_c = sel_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sel_hi_q <= sel_hi_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: rtl/exec_unit_m.sv
// Execute-stage unit: single-cycle RV32I ALU plus multi-cycle M-extension ops,
// with valid/ready handshakes on the request and result sides.
module exec_unit_m
  import exec_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned     SHW     = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            out_valid_q, out_valid_d;

  logic            accept, is_m, mdu_start, mdu_run, mdu_last_c;
  logic [XLEN-1:0] mdu_res_c;
  logic [3:0]      ctrl;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, special_res, base_res;
  logic            a_signed, b_signed, sel_hi, div_zero, div_ovf, div_special;

  assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign is_m     = ENABLE_M & (alu_op == ALUOP_RTYPE) & funct7_0;
  assign mdu_run  = (state_q == ST_MUL) | (state_q == ST_DIV);

  // Decode, operand signedness and divide special cases resolved at accept.
  always_comb begin
    ctrl        = base_ctrl(alu_op, funct7_5, funct3);
    a_signed    = (funct3 == F3_MULH) | (funct3 == F3_MULHSU) |
                  (funct3 == F3_DIV)  | (funct3 == F3_REM);
    b_signed    = (funct3 == F3_MULH) | (funct3 == F3_DIV) | (funct3 == F3_REM);
    sel_hi      = funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
    div_zero    = (op_b == '0);
    div_ovf     = ~funct3[0] & (op_a == INT_MIN) & (op_b == '1);
    div_special = is_m & funct3[2] & (div_zero | div_ovf);
    if (div_zero) special_res = funct3[1] ? op_a : '1;
    else          special_res = funct3[1] ? '0 : op_a;
  end

  always_comb begin
    shamt = op_b[SHW-1:0];
    case (ctrl)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU: alu_res = XLEN'(op_a < op_b);
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = op_a + op_b;
    endcase
    base_res = div_special ? special_res : alu_res;
  end

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .start    (mdu_start),
    .run      (mdu_run),
    .is_div   (funct3[2]),
    .sel_hi   (sel_hi),
    .a_signed (a_signed),
    .b_signed (b_signed),
    .op_a     (op_a),
    .op_b     (op_b),
    .last_c   (mdu_last_c),
    .res_c    (mdu_res_c)
  );

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    mdu_start   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if ((state_q == ST_DONE) && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
        if (accept) begin
          if (is_m && !div_special) begin
            mdu_start   = 1'b1;
            out_valid_d = 1'b0;
            state_d     = funct3[2] ? ST_DIV : ST_MUL;
          end else begin
            result_d    = base_res;
            zero_d      = (base_res == '0);
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (mdu_last_c) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d    = mdu_res_c;
        zero_d      = (mdu_res_c == '0);
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort drops the op but leaves the last presented result in place.
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      result_d    = result_q;
      zero_d      = zero_q;
      mdu_start   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule
